// File: rtl/pocket_audio_pkg.sv
// Shared types and constants for the Pocket audio path.
//   i2s_mode_e     : serial framing, I2S_MODE_STD (I2S) or I2S_MODE_LJ (left-justified)
//   UNDERRUN_CNT_W : width of the optional underrun counter
package pocket_audio_pkg;

    typedef enum logic {
        I2S_MODE_STD = 1'b0,
        I2S_MODE_LJ  = 1'b1
    } i2s_mode_e;

    localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo-sample FIFO with show-ahead read data.
// Ports:
//   clk, reset (async, active high)
//   wr_en / wr_data : push one entry (caller guarantees !full)
//   rd_en / rd_data : pop one entry (caller guarantees !empty); rd_data shows the head
//   full / empty    : occupancy flags
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pocket_i2s_tx.sv
// I2S / left-justified serial transmitter for the Pocket DAC.
// Generates sclk/lrck from clk, buffers stereo samples, shifts them out MSB first.
// Ports:
//   clk, reset            : system clock, async active-high reset
//   in_valid/in_ready     : sample-pair handshake (in_ready = FIFO not full)
//   in_l, in_r            : left/right samples, DATA_W bits two's complement
//   mute                  : zeroes the next frame, sampled at frame start only
//   audio_sclk/lrck/dac   : DAC pins (lrck 0 = left, 1 = right)
//   underrun              : 1-clk pulse when a frame starts with the FIFO empty
//   underrun_cnt          : saturating underrun count, present only when
//                           POCKET_I2S_UNDERRUN_CNT_EN is defined
module pocket_i2s_tx
    import pocket_audio_pkg::*;
#(
    parameter int        DATA_W     = 16,
    parameter int        SLOT_W     = 32,
    parameter int        SCLK_DIV   = 8,
    parameter int        FIFO_DEPTH = 4,
    parameter i2s_mode_e MODE       = I2S_MODE_STD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_l,
    input  logic [DATA_W-1:0] in_r,
    input  logic              mute,
    output logic              audio_sclk,
    output logic              audio_lrck,
    output logic              audio_dac,
`ifdef POCKET_I2S_UNDERRUN_CNT_EN
    output logic              underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`else
    output logic              underrun
`endif
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int BW      = $clog2(FRAME_W);
    localparam int DW      = $clog2(SCLK_DIV);

    localparam logic [BW-1:0] B_LAST = BW'(FRAME_W - 1);
    localparam logic [BW-1:0] B_HALF = BW'(SLOT_W);
    localparam logic [DW-1:0] D_RISE = DW'(SCLK_DIV / 2 - 1);
    localparam logic [DW-1:0] D_FALL = DW'(SCLK_DIV - 1);

    if (DATA_W < 1 || DATA_W > SLOT_W) begin : g_bad_data_w
        $error("pocket_i2s_tx: DATA_W must be 1..SLOT_W");
    end
    if (SCLK_DIV < 4 || (SCLK_DIV % 2) != 0) begin : g_bad_sclk_div
        $error("pocket_i2s_tx: SCLK_DIV must be even and >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pocket_i2s_tx: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [FRAME_W-1:0]   shift_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [2*DATA_W-1:0]  fifo_rd_data;
    logic                 fall_tick;
    logic                 frame_start;
    logic [BW-1:0]        b_next;
    logic [BW-1:0]        b_lead;
    logic [SLOT_W-1:0]    slot_l;
    logic [SLOT_W-1:0]    slot_r;
    logic [FRAME_W-1:0]   load_word;

    assign fall_tick   = (div_cnt == D_FALL);
    assign b_next      = (bit_cnt == B_LAST) ? '0 : bit_cnt + 1'b1;
    // STD framing switches lrck one bit ahead of the data it labels.
    assign b_lead      = (b_next == B_LAST) ? '0 : b_next + 1'b1;
    assign frame_start = fall_tick && (b_next == '0);
    assign in_ready    = !fifo_full;

    // Samples sit MSB-aligned in their slot with zero padding below.
    assign slot_l    = SLOT_W'(fifo_rd_data[2*DATA_W-1 -: DATA_W]) << (SLOT_W - DATA_W);
    assign slot_r    = SLOT_W'(fifo_rd_data[DATA_W-1:0]) << (SLOT_W - DATA_W);
    assign load_word = (fifo_empty || mute) ? '0 : {slot_l, slot_r};

    // The FIFO is popped every frame even when muted, keeping the sample rate.
    audio_sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_valid && !fifo_full),
        .wr_data ({in_l, in_r}),
        .rd_en   (frame_start && !fifo_empty),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_cnt    <= B_LAST;
            shift_q    <= '0;
            audio_sclk <= 1'b0;
            audio_lrck <= 1'b0;
            audio_dac  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            div_cnt  <= fall_tick ? '0 : div_cnt + 1'b1;
            if (div_cnt == D_RISE) audio_sclk <= 1'b1;
            if (fall_tick) begin
                audio_sclk <= 1'b0;
                bit_cnt    <= b_next;
                audio_lrck <= (MODE == I2S_MODE_LJ) ? (b_next >= B_HALF) : (b_lead >= B_HALF);
                if (frame_start) begin
                    audio_dac <= load_word[FRAME_W-1];
                    shift_q   <= {load_word[FRAME_W-2:0], 1'b0};
                    underrun  <= fifo_empty;
                end else begin
                    audio_dac <= shift_q[FRAME_W-1];
                    shift_q   <= {shift_q[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

`ifdef POCKET_I2S_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (frame_start && fifo_empty && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pocket_i2s_tx.sv
module tb_pocket_i2s_tx;
    import pocket_audio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;
    logic        in_ready, sclk, lrck, dac, underrun;
    logic        in_ready_lj, sclk_lj, lrck_lj, dac_lj, underrun_lj;
`ifdef POCKET_I2S_UNDERRUN_CNT_EN
    logic [15:0] ucnt, ucnt_lj;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int ticks = 0;
    int lrck_fall_prev = -1;
    int lrck_fall_last = -1;
    logic lrck_prev = 1'b0;
    logic [63:0] h_dac, h_lrck, h_dac_lj, h_lrck_lj;

    localparam logic [63:0] F_A5      = 64'hA5F0_0000_8001_0000;
    localparam logic [63:0] LRCK_STD  = 64'h0000_0001_FFFF_FFFE;
    localparam logic [63:0] LRCK_LJ   = 64'h0000_0000_FFFF_FFFF;

    pocket_i2s_tx #(.DATA_W(16), .SLOT_W(32), .SCLK_DIV(8), .FIFO_DEPTH(4),
                    .MODE(I2S_MODE_STD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_l(in_l), .in_r(in_r), .mute(mute),
        .audio_sclk(sclk), .audio_lrck(lrck), .audio_dac(dac),
`ifdef POCKET_I2S_UNDERRUN_CNT_EN
        .underrun(underrun), .underrun_cnt(ucnt)
`else
        .underrun(underrun)
`endif
    );

    pocket_i2s_tx #(.DATA_W(16), .SLOT_W(32), .SCLK_DIV(8), .FIFO_DEPTH(4),
                    .MODE(I2S_MODE_LJ)) dut_lj (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_lj),
        .in_l(in_l), .in_r(in_r), .mute(mute),
        .audio_sclk(sclk_lj), .audio_lrck(lrck_lj), .audio_dac(dac_lj),
`ifdef POCKET_I2S_UNDERRUN_CNT_EN
        .underrun(underrun_lj), .underrun_cnt(ucnt_lj)
`else
        .underrun(underrun_lj)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int cur_b();
        return (ticks - 1) % 64;
    endfunction

    task next_fall;
        int n;
        logic prev;
        n = 0;
        do begin
            prev = sclk;
            step;
            n++;
        end while (!(prev && !sclk) && n < 32);
        if (prev && !sclk) begin
            ticks++;
            h_dac     = {h_dac[62:0], dac};
            h_lrck    = {h_lrck[62:0], lrck};
            h_dac_lj  = {h_dac_lj[62:0], dac_lj};
            h_lrck_lj = {h_lrck_lj[62:0], lrck_lj};
            if (lrck_prev && !lrck) begin
                lrck_fall_prev = lrck_fall_last;
                lrck_fall_last = cyc;
            end
            lrck_prev = lrck;
        end else begin
            n_checks++; n_fail++;
            $display("FAIL sclk_fall_timeout: no sclk fall within %0d cycles, required one", n);
        end
    endtask

    task run_frame;
        int g;
        g = 0;
        do begin
            next_fall;
            g++;
        end while (cur_b() != 63 && g < 130);
    endtask

    task do_reset;
        reset = 1'b1;
        in_valid = 1'b0;
        mute = 1'b0;
        step;
        step;
        reset = 1'b0;
        cyc = 0;
        ticks = 0;
        lrck_prev = 1'b0;
        lrck_fall_prev = -1;
        lrck_fall_last = -1;
        h_dac = '0; h_lrck = '0; h_dac_lj = '0; h_lrck_lj = '0;
    endtask

    task push(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        in_l = l;
        in_r = r;
        step;
        in_valid = 1'b0;
    endtask

    task test_reset;
        reset = 1'b1;
        step;
        step;
        n_checks++;
        if ({sclk, lrck, dac, underrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 0000", {sclk, lrck, dac, underrun});
        end
        n_checks++;
        if ({in_ready, in_ready_lj} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 11", {in_ready, in_ready_lj});
        end
        reset = 1'b0;
        repeat (7) step;
        n_checks++;
        if ({underrun, sclk} !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_tick_cycle7 {underrun,sclk}: got %b, required 01", {underrun, sclk});
        end
        step;
        n_checks++;
        if ({underrun, underrun_lj, sclk, dac, lrck} !== 5'b11000) begin
            n_fail++;
            $display("FAIL first_tick_underrun {ur,ur_lj,sclk,dac,lrck}: got %b, required 11000",
                     {underrun, underrun_lj, sclk, dac, lrck});
        end
        step;
        n_checks++;
        if ({underrun, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL underrun_one_clk {underrun,in_ready}: got %b, required 01", {underrun, in_ready});
        end
    endtask

    task test_std_lj;
        logic lj_prev;
        do_reset;
        step;
        push(16'hA5F0, 16'h8001);
        push(16'hA5F0, 16'h8001);
        run_frame;
        n_checks++;
        if (h_dac !== F_A5) begin
            n_fail++;
            $display("FAIL std_frame0_dac: got %h, required %h", h_dac, F_A5);
        end
        n_checks++;
        if (h_lrck !== LRCK_STD) begin
            n_fail++;
            $display("FAIL std_frame0_lrck: got %h, required %h", h_lrck, LRCK_STD);
        end
        n_checks++;
        if (h_dac_lj !== F_A5) begin
            n_fail++;
            $display("FAIL lj_frame0_dac: got %h, required %h", h_dac_lj, F_A5);
        end
        n_checks++;
        if (h_lrck_lj !== LRCK_LJ) begin
            n_fail++;
            $display("FAIL lj_frame0_lrck: got %h, required %h", h_lrck_lj, LRCK_LJ);
        end
        lj_prev = lrck_lj;
        next_fall;
        n_checks++;
        if ({lj_prev, lrck_lj, dac_lj} !== 3'b101) begin
            n_fail++;
            $display("FAIL lj_msb_on_lrck_edge {lrck_before,lrck,dac}: got %b, required 101",
                     {lj_prev, lrck_lj, dac_lj});
        end
        run_frame;
        n_checks++;
        if ({h_dac, h_lrck} !== {F_A5, LRCK_STD}) begin
            n_fail++;
            $display("FAIL std_frame1 dac/lrck: got %h/%h, required %h/%h", h_dac, h_lrck, F_A5, LRCK_STD);
        end
        n_checks++;
        if (lrck_fall_last - lrck_fall_prev !== 512 || lrck_fall_prev < 0) begin
            n_fail++;
            $display("FAIL lrck_period: got %0d clk, required 512", lrck_fall_last - lrck_fall_prev);
        end
    endtask

    task test_back_to_back;
        logic [15:0] el [5];
        logic [15:0] er [5];
        logic [63:0] exp_f;
        do_reset;
        next_fall;
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_starved_underrun: got %b, required 1", underrun);
        end
        for (int k = 0; k < 5; k++) begin
            el[k] = 16'h1100 + 16'(k);
            er[k] = 16'h2200 + 16'(k);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_l = el[k];
            in_r = er[k];
            step;
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full_in_ready: got %b, required 0", in_ready);
        end
        in_l = 16'hDEAD;
        in_r = 16'hBEEF;
        repeat (3) step;
        in_valid = 1'b0;
        while (cur_b() != 63 && ticks < 200) next_fall;
        repeat (7) step;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_in_ready_before_pop: got %b, required 0", in_ready);
        end
        next_fall;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_in_ready_after_pop: got %b, required 1", in_ready);
        end
        push(el[4], er[4]);
        for (int k = 0; k < 5; k++) begin
            run_frame;
            exp_f = {el[k], 16'h0000, er[k], 16'h0000};
            n_checks++;
            if (h_dac !== exp_f) begin
                n_fail++;
                $display("FAIL b2b_order frame %0d: got %h, required %h", k, h_dac, exp_f);
            end
        end
    endtask

    task test_mute;
        do_reset;
        step;
        push(16'h1234, 16'h5678);
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        while (cur_b() != 20 && ticks < 200) next_fall;
        mute = 1'b1;
        run_frame;
        n_checks++;
        if (h_dac !== 64'h1234_0000_5678_0000) begin
            n_fail++;
            $display("FAIL mute_frame_in_flight: got %h, required 1234000056780000", h_dac);
        end
        next_fall;
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL mute_no_underrun: got %b, required 0", underrun);
        end
        while (cur_b() != 10 && ticks < 300) next_fall;
        mute = 1'b0;
        run_frame;
        n_checks++;
        if ({h_dac, h_dac_lj} !== 128'h0) begin
            n_fail++;
            $display("FAIL mute_zero_frame: got %h/%h, required 0", h_dac, h_dac_lj);
        end
        run_frame;
        n_checks++;
        if (h_dac !== 64'h3333_0000_4444_0000) begin
            n_fail++;
            $display("FAIL mute_next_sample: got %h, required 3333000044440000", h_dac);
        end
    endtask

    task test_reset_mid;
        do_reset;
        step;
        push(16'h0F0F, 16'hFFFF);
        push(16'h0F0F, 16'hFFFF);
        while (cur_b() != 40 && ticks < 200) next_fall;
        repeat (5) step;
        n_checks++;
        if ({sclk, lrck, dac} !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_frame_outputs {sclk,lrck,dac}: got %b, required 111", {sclk, lrck, dac});
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({sclk, lrck, dac, underrun, in_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL async_reset_outputs {sclk,lrck,dac,ur,in_ready}: got %b, required 00001",
                     {sclk, lrck, dac, underrun, in_ready});
        end
        do_reset;
        repeat (8) step;
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flushes_fifo underrun: got %b, required 1", underrun);
        end
    endtask

`ifdef POCKET_I2S_UNDERRUN_CNT_EN
    task test_underrun_cnt;
        do_reset;
        n_checks++;
        if (ucnt !== 16'd0) begin
            n_fail++;
            $display("FAIL ucnt_reset: got %h, required 0000", ucnt);
        end
        next_fall;
        run_frame;
        next_fall;
        run_frame;
        next_fall;
        step;
        n_checks++;
        if ({ucnt, ucnt_lj} !== {16'd3, 16'd3}) begin
            n_fail++;
            $display("FAIL ucnt_three: got %h/%h, required 0003/0003", ucnt, ucnt_lj);
        end
        force dut.underrun_cnt = 16'hFFFF;
        step;
        release dut.underrun_cnt;
        run_frame;
        next_fall;
        step;
        n_checks++;
        if (ucnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL ucnt_saturate: got %h, required ffff", ucnt);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_std_lj;
        test_back_to_back;
        test_mute;
        test_reset_mid;
`ifdef POCKET_I2S_UNDERRUN_CNT_EN
        test_underrun_cnt;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
